// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers returned words in a
// small prefetch FIFO, and flushes/refetches on redirect while discarding stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ins_valid,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_data,
    input  logic        ins_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;

    logic [CW:0]     inflight;
    logic [31:0]     target_pc;
    logic            req_fire, rsp_fire, push, pop;

    // Credits cover both buffered and in-flight words, so the FIFO cannot overflow.
    assign inflight      = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
    assign mem_req_valid = !rst && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;

    assign ins_valid = (count_q != '0);
    assign ins_pc    = ins_valid ? mem_q[rd_ptr_q].pc   : 32'h0;
    assign ins_data  = ins_valid ? mem_q[rd_ptr_q].data : 32'h0;

    assign target_pc = redirect_pc & ~32'h3;
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign rsp_fire  = mem_rsp_valid && (outstanding_q != '0);
    assign pop       = ins_valid && ins_ready;
    assign push      = rsp_fire && !redirect_valid && (drop_cnt_q == '0);

    always_comb begin
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be skipped.
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            drop_cnt_d = outstanding_d;
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_fire && (drop_cnt_q != '0))
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: rsp_pc_q, data: mem_rsp_data};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                rsp_pc_d        = rsp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: prefetch FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mem_req_valid  output  1  fetch request to instruction memory.
REQ-006 mem_req_addr  output  32  fetch address, word aligned.
REQ-007 mem_req_ready  input  1  memory accepts request this cycle.
REQ-008 mem_rsp_valid  input  1  read data valid; responses return in request order, latency >=1 cycle.
REQ-009 mem_rsp_data  input  32  instruction word.
REQ-010 ins_valid  output  1  instruction available to cpu.
REQ-011 ins_pc  output  32  pc of presented instruction.
REQ-012 ins_data  output  32  presented instruction word.
REQ-013 ins_ready  input  1  cpu consumes instruction this cycle.
REQ-014 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  input  32  new fetch target.

Function
REQ-016 Request accepted when mem_req_valid && mem_req_ready; fetch_pc then += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
REQ-017 mem_req_addr = fetch_pc; mem_req_valid, once high, holds with addr unchanged until accepted or redirect.
REQ-018 mem_req_valid = !redirect_valid && (fifo_count + outstanding < DEPTH); FIFO never overflows.
REQ-019 outstanding: +1 per accepted request, -1 per mem_rsp_valid; both in one cycle -> unchanged.
REQ-020 Response not dropped: push {rsp_pc, mem_rsp_data} to FIFO; rsp_pc += 4; ins_valid earliest cycle after mem_rsp_valid.
REQ-021 ins_valid = FIFO non-empty; ins_pc/ins_data = head entry; pop on ins_valid && ins_ready.
REQ-022 Push and pop same cycle: count unchanged, order kept; push into empty FIFO with ins_ready high does not bypass.
REQ-023 Redirect cycle: FIFO flushed; rsp that cycle discarded; no request issued; handshake completing that cycle is valid for cpu.
REQ-024 Redirect next state: fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}; drop_cnt = outstanding after this cycle's decrement.
REQ-025 While drop_cnt > 0: each mem_rsp_valid decrements drop_cnt and outstanding, data discarded, no push.
REQ-026 Redirect during nonzero drop_cnt: drop_cnt reloads per REQ-024 (not added).
REQ-027 Requests to new target issue immediately after redirect, not waiting for drop_cnt = 0, if REQ-018 permits.
REQ-028 mem_rsp_valid with outstanding = 0 ignored (protocol error, no state change).

Reset
REQ-029 During rst: mem_req_valid=0, ins_valid=0, ins_pc=0, ins_data=0, FIFO empty, outstanding=0, drop_cnt=0, fetch_pc=rsp_pc=RESET_PC.
REQ-030 Async assert acts immediately mid-transaction; in-flight responses after release not expected; first cycle after release: mem_req_valid=1, mem_req_addr=RESET_PC.

Verification
REQ-031 Reset release, mem_req_ready=1, 1-cycle rsp with 0x00000013, ins_ready=1 -> ins_pc 0x0,0x4,0x8 in consecutive cycles, ins_data 0x00000013.
REQ-032 ins_ready=0, DEPTH=4 -> exactly 4 requests accepted, mem_req_valid low; one pop -> one more request.
REQ-033 3 outstanding (0x10,0x14,0x18), redirect_pc=0x101 -> next req addr 0x100; 3 rsps dropped; first ins_pc 0x100.
REQ-034 Redirect in same cycle as rsp, 2 outstanding -> drop_cnt=1; next rsp dropped, following rsp pushed.
REQ-035 RESET_PC=0xFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst asserted with FIFO full and 2 outstanding -> all outputs at reset values same cycle; fetch restarts at RESET_PC.
